// File: rtl/binary_bcd_converter_pkg.sv
// Shared constants and types for the binary-to-BCD converter and the
// seven-segment display driver that consumes its packed digits.
package binary_bcd_converter_pkg;

  // Default binary input width (also the number of shift iterations).
  localparam int NBITS_DEFAULT = 16;

  // One BCD digit is a nibble.
  localparam int DIGIT_W = 4;

  // The accumulator carries five digits so that 65535 fits before the
  // overflow decision is made.
  localparam int ACC_DIGITS = 5;
  localparam int ACC_W      = DIGIT_W * ACC_DIGITS;

  // The display shows four digits.
  localparam int OUT_DIGITS = 4;
  localparam int OUT_W      = DIGIT_W * OUT_DIGITS;

  // Digit code the display driver renders as an unlit digit.
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

  // Largest value that fits on four decimal digits.
  localparam int MAX_DISPLAY = 9999;

  // Converter control states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/binary_bcd_converter_bcd_add3.sv
// Single-digit correction for the shift-and-add-3 algorithm: a digit of 5
// or more gets +3 so that the following left shift carries into the next
// decimal digit. Only values 0..9 reach this block.
module bcd_add3
  import binary_bcd_converter_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // Conditional +3 on digits 5..9.
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/binary_bcd_converter.sv
// Sequential binary-to-BCD converter, one bit per clock. A 16-bit value is
// turned into four packed BCD digits (thousands first) for the display
// driver. Values above 9999 produce the blank code on every digit and raise
// Overflow. Bcd/Overflow only change on the Done edge so the display never
// sees a half-converted value.
module binary_bcd_converter
  import binary_bcd_converter_pkg::*;
#(
  parameter int                 NBITS = NBITS_DEFAULT,
  parameter logic [DIGIT_W-1:0] BLANK = BLANK_CODE
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [NBITS-1:0] Number,
  output logic             Busy,
  output logic             Done,
  output logic [OUT_W-1:0] Bcd,
  output logic             Overflow
);

  localparam int             CNT_W    = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);
  localparam int             SH_W     = ACC_W + NBITS;

  state_t           state_reg, state_next;
  logic [NBITS-1:0] bin_reg,   bin_next;
  logic [ACC_W-1:0] acc_reg,   acc_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  logic             busy_reg,  busy_next;
  logic             done_reg,  done_next;
  logic [OUT_W-1:0] bcd_reg,   bcd_next;
  logic             ovf_reg,   ovf_next;

  // Accumulator after the per-digit +3 correction, and the combined
  // {bcd,bin} register after this cycle's left shift.
  logic [ACC_W-1:0] acc_adj;
  logic [SH_W-1:0]  shifted;
  logic [DIGIT_W-1:0] ten_thousands;

  genvar gi;
  generate
    for (gi = 0; gi < ACC_DIGITS; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .din  (acc_reg[gi*DIGIT_W +: DIGIT_W]),
        .dout (acc_adj[gi*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  assign shifted       = {acc_adj, bin_reg} << 1;
  assign ten_thousands = shifted[SH_W-1 -: DIGIT_W];

  // State, datapath and output registers; reset aborts any conversion.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      bcd_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      bcd_reg   <= bcd_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Next-state and datapath: accept in IDLE, shift NBITS times, then
  // publish the result together with a one-cycle Done.
  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    bcd_next   = bcd_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      IDLE: begin
        if (Start) begin
          bin_next   = Number;
          acc_next   = '0;
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        bin_next = shifted[NBITS-1:0];
        acc_next = shifted[NBITS +: ACC_W];
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_CNT) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          if (ten_thousands == '0) begin
            bcd_next = shifted[NBITS +: OUT_W];
            ovf_next = 1'b0;
          end else begin
            bcd_next = {OUT_DIGITS{BLANK}};
            ovf_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign Busy     = busy_reg;
  assign Done     = done_reg;
  assign Bcd      = bcd_reg;
  assign Overflow = ovf_reg;

endmodule

// File: doc/binary_bcd_converter.md
# binary_bcd_converter

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that sits directly upstream of the four-digit seven-segment display driver. It converts a 16-bit unsigned value into four packed BCD digits, thousands first, which the display driver multiplexes onto the digits without doing any division itself. Values above 9999 produce the display's blank code on all digits plus an overflow flag.

## Interface
- NBITS, 16: binary input width; also the number of shift iterations.
- BLANK, 4'hF: digit code driven on every digit when the value exceeds 9999.
- Clk  input  1  system clock (100 MHz board clock); all state changes on rising edge.
- Rst  input  1  reset, synchronous and active-high.
- Start  input  1  request conversion; sampled only in IDLE.
- Number  input  NBITS  unsigned binary value; sampled on the accepting Start edge only.
- Busy  output  1  conversion in progress.
- Done  output  1  one-cycle pulse; Bcd/Overflow updated in the same cycle.
- Bcd  output  16  [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units; holds the last result.
- Overflow  output  1  last converted value > 9999; holds until the next Done.

## Operation
- States: IDLE, SHIFT.
- IDLE: if Start=1, load Number into the binary shift register, clear the 20-bit BCD accumulator (5 digits), clear the iteration counter, go to SHIFT, Busy<=1.
- SHIFT: each cycle, every BCD digit >= 5 gets +3 (combinational), then {bcd,bin} shifts left by 1; counter increments.
- On the NBITS-th shift: register the result, Done<=1, Busy<=0, return to IDLE.
- Result: if the ten-thousands digit is 0, Bcd <= low four digits and Overflow <= 0. Otherwise Bcd <= {4{BLANK}} and Overflow <= 1.
- Start while Busy: ignored, no queuing.
- Number changes during SHIFT: ignored; the sampled copy is used.
- Start during the Done cycle: accepted, because the state is already IDLE. Done falls on the next edge and Busy rises on that same edge.
- Bcd/Overflow change only on Done edges, so the display never shows partial results.
- Width rules:
  - Accumulator is 20 bits, enough for 65535.
  - Counter is $clog2(NBITS+1) bits.
  - The add-3 is applied to digit values 5..9 only. Values 10..15 cannot occur.

## Timing
- Reset values: state IDLE, Busy=0, Done=0, Bcd=16'h0000, Overflow=0, counter=0, internal registers 0.
- Rst asserted mid-conversion: aborts at that edge and all outputs take their reset values. Rst has priority over Start.
- Latency:
  - Start accepted at edge k; Busy high after edges k through k+NBITS-1.
  - Shifts occur at edges k+1 through k+NBITS.
  - At edge k+NBITS: Bcd/Overflow update, Done=1, Busy=0.
  - Done low again after edge k+NBITS+1.
- With NBITS=16, latency is 16 cycles; maximum throughput is one conversion per 17 cycles.

## Structure
- Shared package holds:
  - NBITS default, digit width 4, BLANK code 4'hF, max displayable value 9999.
  - The state enum {IDLE, SHIFT}; the display driver uses the same BLANK constant.
- One sub-module, bcd_add3: combinational 4-bit digit correction (out = in >= 5 ? in+3 : in), instantiated 5 times.
- Top contains the FSM, counter, shift registers and output registers.

## Test plan
- Reset, then Start with Number=16'd4092 -> Done exactly 16 cycles after the accepting edge, Bcd=16'h4092, Overflow=0.
- Number=0, then 9999 -> Bcd=16'h0000, then Bcd=16'h9999; Overflow=0 both times.
- Number=10000, then 65535 -> Bcd=16'hFFFF, Overflow=1 both times.
- Start 1234, then pulse Start with 5678 on cycles 3 and 10 of the conversion -> single Done, Bcd=16'h1234, Busy continuous.
- Start 4321, assert Rst at cycle 8 -> Busy=0, Done=0, Bcd=0 the next cycle. Then Start 42 -> Bcd=16'h0042.
- Start 17, then hold Start=1 with Number=900 during the Done cycle -> second Done 17 cycles after the first, Bcd=16'h0900.
